// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game sequencer.
// Contents: state encoding, text-region enable bit positions, BCD digit limit.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  // Bit positions inside text_en = {score, logo, rule, over}
  localparam int TXT_SCORE = 3;
  localparam int TXT_LOGO  = 2;
  localparam int TXT_RULE  = 1;
  localparam int TXT_OVER  = 0;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/pong_timer.sv
// Hold-off timer: 7-bit down-counter stepped by the frame refresh tick.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   load       : reload with TICKS (wins over a same-cycle tick)
//   tick       : decrement by one when the count is nonzero
//   done       : count is zero
module pong_timer #(
  parameter int TICKS = 120
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic done
);

  logic [6:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= 7'(TICKS);
    else if (tick && (count != 7'd0))
      count <= count - 7'd1;
  end

  assign done = (count == 7'd0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: game state, ball count, two-digit BCD score and the
// hold-off timer that paces new-ball and game-over screens.
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   btn             : debounced buttons, any nonzero value is a press
//   hit, miss       : one-cycle strobes from the graphics generator
//   refr_tick       : one-cycle strobe per frame
//   gra_still       : hold ball/paddles at start position
//   text_en         : {score, logo, rule, over} text-region enables
//   dig1, dig0      : BCD score tens / units
//   ball            : balls remaining
//   state           : current state code
//
// state   | meaning
// NEWGAME | title screen, waiting for a press to start a game
// PLAY    | ball in motion, counting hits and watching for misses
// NEWBALL | ball lost, hold-off then press to serve the next ball
// OVER    | last ball lost, hold-off then back to title screen
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALLS       = 3,
  parameter int TIMER_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
  input  logic       refr_tick,
  output logic       gra_still,
  output logic [3:0] text_en,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic [1:0] ball,
  output logic [1:0] state
);

  localparam logic [1:0] BALLS_FULL = 2'(BALLS);

  state_t     state_q, state_d;
  logic [3:0] dig1_q, dig0_q;
  logic [1:0] ball_q;
  logic       timer_load, timer_done;
  logic       score_clr, score_inc;
  logic       ball_full, ball_start, ball_dec;
  logic       press;

  assign press = (btn != 2'b00);

  pong_timer #(.TICKS(TIMER_TICKS)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .tick  (refr_tick),
    .done  (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= ST_NEWGAME;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    score_clr  = 1'b0;
    score_inc  = 1'b0;
    ball_full  = 1'b0;
    ball_start = 1'b0;
    ball_dec   = 1'b0;
    gra_still  = 1'b1;
    text_en    = '0;
    case (state_q)
      ST_NEWGAME: begin
        text_en[TXT_SCORE] = 1'b1;
        text_en[TXT_LOGO]  = 1'b1;
        text_en[TXT_RULE]  = 1'b1;
        if (press) begin
          state_d    = ST_PLAY;
          score_clr  = 1'b1;
          ball_start = 1'b1;
        end
      end
      ST_PLAY: begin
        gra_still          = 1'b0;
        text_en[TXT_SCORE] = 1'b1;
        score_inc          = hit;
        if (miss) begin
          timer_load = 1'b1;
          if (ball_q == 2'd0) begin
            state_d = ST_OVER;
          end else begin
            state_d  = ST_NEWBALL;
            ball_dec = 1'b1;
          end
        end
      end
      ST_NEWBALL: begin
        text_en[TXT_SCORE] = 1'b1;
        // Timer was reloaded on entry, so a held button waits out the hold-off.
        if (timer_done && press)
          state_d = ST_PLAY;
      end
      ST_OVER: begin
        text_en[TXT_SCORE] = 1'b1;
        text_en[TXT_OVER]  = 1'b1;
        if (timer_done) begin
          state_d   = ST_NEWGAME;
          ball_full = 1'b1;
        end
      end
      default: state_d = ST_NEWGAME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      ball_q <= BALLS_FULL;
    else if (ball_full)
      ball_q <= BALLS_FULL;
    else if (ball_start)
      ball_q <= BALLS_FULL - 2'd1;
    else if (ball_dec)
      ball_q <= ball_q - 2'd1;
  end

  // BCD score, wraps 99 -> 00 silently.
  always_ff @(posedge clk) begin
    if (reset || score_clr) begin
      dig1_q <= 4'd0;
      dig0_q <= 4'd0;
    end else if (score_inc) begin
      if (dig0_q == BCD_MAX) begin
        dig0_q <= 4'd0;
        dig1_q <= (dig1_q == BCD_MAX) ? 4'd0 : dig1_q + 4'd1;
      end else begin
        dig0_q <= dig0_q + 4'd1;
      end
    end
  end

  assign dig1  = dig1_q;
  assign dig0  = dig0_q;
  assign ball  = ball_q;
  assign state = state_q;

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Top-level game sequencer for the text-overlay Pong build. Tracks game state (new game, play, new ball, game over), ball count, a two-digit BCD score and a 2-second hold-off timer. Drives the graphics freeze control and per-region text enables that the top level uses to multiplex the graphics and font-text RGB paths ahead of the RGB buffer. Sits beside `vga_sync`; consumes the per-frame refresh tick and the hit/miss strobes from the graphics generator.

## Interface
- `BALLS`, 3, balls per game; legal range 1..3.
- `TIMER_TICKS`, 120, refresh ticks in the hold-off interval (2 s at 60 Hz); legal range 1..127.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `btn` in 2: debounced push-buttons; any nonzero value is a "press".
- `hit` in 1: one-cycle strobe, ball struck by paddle.
- `miss` in 1: one-cycle strobe, ball passed paddle.
- `refr_tick` in 1: one-cycle strobe at start of each frame (pixel_y = 481, pixel_x = 0).
- `gra_still` out 1: 1 = graphics generator holds ball/paddle at start position.
- `text_en` out 4: {score, logo, rule, over} text-region enables.
- `dig1`, `dig0` out 4 each: BCD score tens/units.
- `ball` out 2: balls remaining.
- `state` out 2: current state code, for debug/LEDs.

## Operation
- States (Moore, registered): NEWGAME=00, PLAY=01, NEWBALL=10, OVER=11.
- Reset: state NEWGAME, `ball`=BALLS, `dig1:dig0`=00, timer count 0. Outputs after reset: `gra_still`=1, `text_en`=1110, `state`=00.
- NEWGAME: `gra_still`=1, `text_en`=1110. `btn`≠0 → PLAY; same edge: score cleared to 00, `ball` ← BALLS−1.
- PLAY: `gra_still`=0, `text_en`=1000. `hit` → score +1. `miss` with `ball`=0 → OVER; `miss` with `ball`>0 → NEWBALL, `ball` ← `ball`−1. Either `miss` transition loads timer with TIMER_TICKS.
- NEWBALL: `gra_still`=1, `text_en`=1000. timer done AND `btn`≠0 → PLAY. Button held through entry does not bypass timer.
- OVER: `gra_still`=1, `text_en`=1001. timer done → NEWGAME; `ball` ← BALLS on that edge.
- Score: BCD; units 9 → 0 with tens +1; 99 + 1 → 00 (wrap, no flag).
- `hit` and `miss` same cycle in PLAY: score increments AND miss transition taken.
- `hit`/`miss` outside PLAY: ignored.
- Timer: 7-bit down-counter; load has priority over decrement; decrements by 1 on `refr_tick` when nonzero; done = (count==0), combinational from register.

## Timing
- All state/counters update on rising `clk`; outputs decode registered state → every response visible one cycle after the causing input.
- Hold-off length: exactly TIMER_TICKS `refr_tick` pulses after the load edge; earliest exit is the cycle after the TIMER_TICKS-th tick.
- `refr_tick` on the load cycle is discarded.
- `reset` mid-game: next cycle all registers at reset values regardless of state or timer.
- No handshake; strobes assumed one cycle wide, multi-cycle `hit` counts once per cycle asserted.

## Structure
- Package `pong_pkg`: state encoding constants, `text_en` bit indices (SCORE=3, LOGO=2, RULE=1, OVER=0), BCD max digit 9.
- Sub-module `pong_timer`: load/decrement/done counter, parameterised by TIMER_TICKS.
- BCD score counter and ball counter inline in `pong_game_ctrl`.

## Test plan
- Reset, then `btn`=01 one cycle → state 01, `ball`=2, score 00, `gra_still`=0, `text_en`=1000.
- In PLAY, 100 `hit` strobes from 00 → score passes 09→10, 99→00; final 00.
- `miss` with `ball`=2 → NEWBALL, `ball`=1; `btn` held constantly → PLAY only after 120 `refr_tick`, not 119.
- Third `miss` (`ball`=0) → OVER, `text_en`=1001; after 120 ticks → NEWGAME, `ball`=3, score retained until next press clears it.
- `hit`+`miss` same cycle at score 41, `ball`=1 → score 42, NEWBALL, `ball`=0; `refr_tick` coincident with load → still 120 ticks required.
- `reset` asserted in NEWBALL with timer at 57 → next cycle NEWGAME, score 00, `ball`=3, timer 0.
